// File: rtl/fetch_buffer_pkg.sv
// Shared core constants and the queue entry layout used by the fetch buffer.
package fetch_buffer_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fb_entry_t;

endpackage

// File: rtl/fetch_buffer_dff.sv
// Generic register cell: clocked on the rising edge, asynchronously cleared to zero.
module dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // State register with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= {WIDTH{1'b0}};
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Show-ahead instruction queue between fetch and decode; a flush discards all wrong-path entries.
import fetch_buffer_pkg::*;

module fetch_buffer #(
    parameter  int DEPTH = 4,
    localparam int PTRW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            FetchValid_IF,
    input  logic [31:0]     FetchData_IF,
    input  logic [31:0]     FetchPc_IF,
    input  logic            Stall_ID,
    input  logic            Flush,
    output logic            FetchStall_IF,
    output logic            InstrValid_ID,
    output logic [31:0]     Instr_ID,
    output logic [31:0]     Pc_ID,
    output logic [PTRW:0]   Count
);

    localparam logic [PTRW:0] DEPTH_CNT = (PTRW+1)'(DEPTH);

    logic [PTRW-1:0] wptr_r;
    logic [PTRW-1:0] rptr_r;
    logic [PTRW:0]   count_r;
    logic [PTRW-1:0] wptr_nxt_s;
    logic [PTRW-1:0] rptr_nxt_s;
    logic [PTRW:0]   count_nxt_s;
    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            pop_s;
    fb_entry_t       head_s;
    fb_entry_t       mem_r [DEPTH];

    // Full is judged on the registered count, so a pop cannot free a slot for the same cycle's push
    assign full_s  = (count_r == DEPTH_CNT);
    assign empty_s = (count_r == {(PTRW+1){1'b0}});
    assign push_s  = FetchValid_IF & ~full_s & ~Flush;
    assign pop_s   = ~empty_s & ~Stall_ID & ~Flush;

    // Next pointer and occupancy; flush overrides any concurrent push/pop
    always_comb begin
        wptr_nxt_s  = wptr_r;
        rptr_nxt_s  = rptr_r;
        count_nxt_s = count_r;
        if (Flush) begin
            wptr_nxt_s  = {PTRW{1'b0}};
            rptr_nxt_s  = {PTRW{1'b0}};
            count_nxt_s = {(PTRW+1){1'b0}};
        end else begin
            if (push_s) begin
                wptr_nxt_s = wptr_r + PTRW'(1);
            end else begin
                wptr_nxt_s = wptr_r;
            end
            if (pop_s) begin
                rptr_nxt_s = rptr_r + PTRW'(1);
            end else begin
                rptr_nxt_s = rptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + (PTRW+1)'(1);
                2'b01:   count_nxt_s = count_r - (PTRW+1)'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    dff #(.WIDTH(PTRW))   u_wptr  (.clk(clk), .reset(reset), .d(wptr_nxt_s),  .q(wptr_r));
    dff #(.WIDTH(PTRW))   u_rptr  (.clk(clk), .reset(reset), .d(rptr_nxt_s),  .q(rptr_r));
    dff #(.WIDTH(PTRW+1)) u_count (.clk(clk), .reset(reset), .d(count_nxt_s), .q(count_r));

    // Entry storage; not reset because empty entries are never presented
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r] <= '{pc: FetchPc_IF, instr: FetchData_IF};
        end
    end

    assign head_s        = mem_r[rptr_r];
    assign FetchStall_IF = full_s;
    assign InstrValid_ID = ~empty_s;
    assign Instr_ID      = empty_s ? INSTR_NOP : head_s.instr;
    assign Pc_ID         = empty_s ? 32'h0000_0000 : head_s.pc;
    assign Count         = count_r;

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction queue between the fetch stage and the decode stage of the pipelined MIPS core.
- Decouples fetch from decode back-pressure: fetch keeps pushing while decode stalls, until the queue is full.
- On a control-flow redirect (jump in ID, taken branch in EX), all queued wrong-path instructions are discarded.
- Presents the head instruction and its PC to decode as a show-ahead (first-word-fall-through) FIFO.

Parameters:
- DEPTH, 4, number of queued entries; power of two, minimum 2.
- PTRW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- FetchValid_IF  input  1  fetch presents a valid instruction this cycle.
- FetchData_IF  input  32  fetched instruction word.
- FetchPc_IF  input  32  PC of FetchData_IF.
- Stall_ID  input  1  decode cannot accept an instruction this cycle.
- Flush  input  1  redirect (Jump_ID OR BranchTaken_EX); discard all contents.
- FetchStall_IF  output  1  queue full; fetch must hold its PC and data.
- InstrValid_ID  output  1  Instr_ID/Pc_ID hold a valid queued instruction.
- Instr_ID  output  32  head instruction; 32'h0 (NOP) when empty.
- Pc_ID  output  32  head PC; 32'h0 when empty.
- Count  output  PTRW+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH entries of {pc[31:0], instr[31:0]}; write pointer, read pointer (PTRW bits, wrap modulo DEPTH) and occupancy counter (PTRW+1 bits).
- Reset (async, immediate): pointers = 0, Count = 0. The outputs are then InstrValid_ID = 0, Instr_ID = 0, Pc_ID = 0, FetchStall_IF = 0. Storage contents are don't-care.
- Full = (Count == DEPTH); Empty = (Count == 0). Both are derived from registered Count only.
- FetchStall_IF = Full, combinational from Count.
- Push = FetchValid_IF & ~Full & ~Flush. Writes entry[wptr], then wptr++.
- Pop = ~Empty & ~Stall_ID & ~Flush. rptr++.
- Count next value:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop together.
- Latency: an instruction pushed in cycle N is visible on Instr_ID in cycle N+1 at the earliest. There is no empty-queue bypass.
- Outputs: InstrValid_ID = ~Empty. Instr_ID and Pc_ID = entry[rptr] when ~Empty, else 32'h0.
- Full and pop in the same cycle: the push is still refused, because Full is evaluated before the pop. The freed slot becomes usable the next cycle.
- Flush has top priority:
  - Next cycle: pointers = 0, Count = 0.
  - The concurrent push and pop are both suppressed. The decode consumer ignores the head during a flush cycle.
- Flush while empty: no effect beyond the pointer reset.
- Pointer wrap: DEPTH - 1 -> 0 with no bubble. Occupancy stays exact across wraps.
- Reset mid-operation: contents are lost and the reset values apply immediately.
- Stall_ID while Empty: no effect.
- FetchValid_IF while Full: the word is not stored. Fetch is required to re-present it while FetchStall_IF = 1.

Decomposition:
- Shared core package constants:
  - INSTR_NOP = 32'h0000_0000.
  - Instruction and PC widths (32).
- Pointer and counter registers reuse the existing dff register cell (async reset to 0). No other sub-module is needed.
- Storage is a register array inside fetch_buffer, written on the clock edge only and not reset.
- Top-level integration:
  - Flush = Jump_ID | BranchTaken_EX.
  - FetchStall_IF ORs into the fetch stall.
  - Instr_ID replaces the direct FetchData_IF path into decode.

Test Plan:
1. Reset, then push 3 words (PC 0x00/0x04/0x08, instr 0x20080005/0x20090003/0x01095020) with Stall_ID = 0 -> each appears on Instr_ID one cycle after its push, in order; Count peaks at 1; InstrValid_ID drops to 0 after the third.
2. Stall_ID = 1 with continuous pushes -> Count reaches 4 after 4 cycles, FetchStall_IF = 1, the 5th word is not stored; release Stall_ID -> words pop in order, FetchStall_IF drops 1 cycle after the first pop.
3. Full queue, Stall_ID = 0, FetchValid_IF = 1 in the same cycle -> the pop happens, the push is refused, Count goes 4 -> 3; the next cycle push is accepted and Count stays 3.
4. 3 entries queued, Flush = 1 with FetchValid_IF = 1 -> next cycle Count = 0, InstrValid_ID = 0, Instr_ID = 0; the concurrent word is absent; a new push at PC 0x40 appears alone.
5. 10 push/pop cycles, wrapping the pointers twice, with random Stall_ID -> output order matches the push order exactly; Count never exceeds 4 and never underflows.
6. Assert reset with 2 entries queued, mid-cycle -> outputs go to zero without waiting for a clock edge; after release, the first push is the first output.
